// File: rtl/nonrestoring_div.sv
// Sequential unsigned divider using the non-restoring algorithm.
// Dividend and divisor share data_in on consecutive cycles; one quotient bit is produced per CALC cycle.
module nonrestoring_div #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOADM,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t             state;
    logic [WIDTH:0]     a_reg;
    logic [WIDTH-1:0]   q_reg;
    logic [WIDTH-1:0]   m_reg;
    logic [CNT_W-1:0]   count;

    logic [WIDTH:0]     m_ext;
    logic [WIDTH:0]     a_shift;
    logic [WIDTH:0]     a_step;
    logic [WIDTH:0]     a_fix;

    // The pre-shift sign of A selects subtract or add; FIX undoes a negative final remainder.
    always_comb begin
        m_ext   = {1'b0, m_reg};
        a_shift = {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};
        a_step  = a_reg[WIDTH] ? (a_shift + m_ext) : (a_shift - m_ext);
        a_fix   = a_reg[WIDTH] ? (a_reg + m_ext) : a_reg;
    end

    // NOTE: all state lives in this one clocked block and is assigned with <= so every
    // register samples the pre-edge values; blocking = here would create ordering races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            dbz       <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            a_reg     <= '0;
            q_reg     <= '0;
            m_reg     <= '0;
            count     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        q_reg <= data_in;
                        a_reg <= '0;
                        dbz   <= 1'b0;
                        busy  <= 1'b1;
                        state <= LOADM;
                    end
                end
                LOADM: begin
                    m_reg <= data_in;
                    count <= CNT_W'(WIDTH);
                    if (data_in == '0) begin
                        dbz       <= 1'b1;
                        quotient  <= '1;
                        remainder <= q_reg;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    a_reg <= a_step;
                    q_reg <= {q_reg[WIDTH-2:0], ~a_step[WIDTH]};
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    a_reg     <= a_fix;
                    quotient  <= q_reg;
                    remainder <= a_fix[WIDTH-1:0];
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= DONE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nonrestoring_div.sv
// Scoreboard bench for nonrestoring_div: stimulus pushes expected results, a monitor checks each done pulse.
module tb_nonrestoring_div;

    localparam int WIDTH = 16;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dbz;
        int               cyc;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic             busy;
    logic             done;
    logic             dbz;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    int   checks;
    int   fails;
    int   cyc;
    exp_t sb[$];

    nonrestoring_div #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data_in  (data_in),
        .busy     (busy),
        .done     (done),
        .dbz      (dbz),
        .quotient (quotient),
        .remainder(remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", 32'(quotient), 32'(e.q));
                check("remainder", 32'(remainder), 32'(e.r));
                check("dbz", 32'(dbz), 32'(e.dbz));
                check("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Called at a negedge; drives dividend then divisor and returns two cycles after start.
    task automatic issue(input logic [WIDTH-1:0] dividend, input logic [WIDTH-1:0] divisor,
                         input logic [WIDTH-1:0] exp_q, input logic [WIDTH-1:0] exp_r,
                         input logic exp_dbz, input bit push);
        exp_t e;
        e.q   = exp_q;
        e.r   = exp_r;
        e.dbz = exp_dbz;
        e.cyc = cyc + ((divisor == '0) ? 2 : WIDTH + 3);
        if (push) sb.push_back(e);
        start   = 1'b1;
        data_in = dividend;
        @(negedge clk);
        start   = 1'b0;
        data_in = divisor;
        @(negedge clk);
        data_in = '0;
    endtask

    task automatic drain();
        int budget;
        budget = 200;
        while (sb.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        checks  = 0;
        fails   = 0;
        rst     = 1'b1;
        start   = 1'b1;
        data_in = 16'h5555;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dbz", 32'(dbz), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        rst     = 1'b0;
        start   = 1'b0;
        data_in = '0;
        @(negedge clk);

        issue(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b1);
        check("busy_in_calc", 32'(busy), 32'd1);
        drain();
        issue(16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b1);
        drain();
        issue(16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 1'b1);
        drain();

        issue(16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b1);
        @(negedge clk);
        check("busy_after_dbz", 32'(busy), 32'd0);
        drain();

        // A start pulse during CALC must be ignored.
        issue(16'hFFFF, 16'h0100, 16'h00FF, 16'h00FF, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        start   = 1'b1;
        data_in = 16'd3;
        @(negedge clk);
        start   = 1'b0;
        data_in = '0;
        drain();

        // Reset at CALC cycle 8 aborts with no done pulse.
        issue(16'd1000, 16'd3, 16'd0, 16'd0, 1'b0, 1'b0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_quotient", 32'(quotient), 32'd0);
        check("abort_remainder", 32'(remainder), 32'd0);
        issue(16'd50, 16'd5, 16'd10, 16'd0, 1'b0, 1'b1);
        drain();

        // Back-to-back: the second start arrives in the DONE cycle of the first.
        issue(16'd9, 16'd4, 16'd2, 16'd1, 1'b0, 1'b1);
        repeat (17) @(negedge clk);
        check("b2b_done_cycle", 32'(done), 32'd1);
        issue(16'd8, 16'd8, 16'd1, 16'd0, 1'b0, 1'b1);
        drain();

        repeat (5) @(negedge clk);
        check("final_busy", 32'(busy), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
